// File: rtl/async_queue_sink_rd.sv
// rtl/async_queue_sink_rd.sv - sink-domain read side of an async crossing queue
//
// Purpose:
//   Synchronises the source's gray write index and alive flag into the sink
//   clock. Reads entries directly from the source-owned storage array and
//   presents them on a registered valid/ready dequeue port. Returns the gray
//   read index and a sink-alive flag to the source side.
//
// Ports:
//   clock        sink-domain clock
//   reset        synchronous, active-high reset
//   widx_gray    source write index (gray), asynchronous to clock
//   source_valid source-alive flag, asynchronous to clock
//   mem_flat     source storage, entry i at [i*WIDTH +: WIDTH]
//   ridx_gray    sink read index (gray), registered
//   sink_valid   sink-alive flag to the source
//   deq_valid    dequeue payload valid
//   deq_ready    dequeue consumer ready
//   deq_bits     dequeue payload, registered
//   gray_err     sticky synchronised-pointer error
//
// Optional feature macro: ASYNC_SINK_GRAY_CHECK_EN
//   Defined   : gray_err flags a synchronised write index that moved by more
//               than one bit while the source was alive.
//   Undefined : gray_err is tied to 0 and the checker is absent.

module async_queue_sink_rd #(
    parameter int DEPTH_LOG2  = 3,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [DEPTH_LOG2:0]               widx_gray,
    input  logic                              source_valid,
    input  logic [WIDTH*(2**DEPTH_LOG2)-1:0]  mem_flat,
    output logic [DEPTH_LOG2:0]               ridx_gray,
    output logic                              sink_valid,
    output logic                              deq_valid,
    input  logic                              deq_ready,
    output logic [WIDTH-1:0]                  deq_bits,
    output logic                              gray_err
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    // Synchroniser chains: plain flop-to-flop, no logic in between.
    logic [PW-1:0]          widx_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] src_sync;
    logic [PW-1:0]          widx_s;
    logic                   src_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                widx_sync[i] <= '0;
            end
            src_sync <= '0;
        end else begin
            widx_sync[0] <= widx_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                widx_sync[i] <= widx_sync[i-1];
            end
            src_sync <= {src_sync[SYNC_STAGES-2:0], source_valid};
        end
    end

    assign widx_s = widx_sync[SYNC_STAGES-1];
    assign src_ok = src_sync[SYNC_STAGES-1];

    // Storage view as an indexable array.
    logic [WIDTH-1:0] mem_entry [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_entry[i] = mem_flat[i*WIDTH +: WIDTH];
        end
    end

    // Read pointer and dequeue register.
    logic [PW-1:0] rbin;
    logic [PW-1:0] next_rbin;
    logic          empty;
    logic          load;

    assign next_rbin = rbin + 1'b1;
    // Gray compare; the MSB separates a full queue from an empty one.
    assign empty     = (ridx_gray == widx_s);
    assign load      = src_ok & ~empty & (~deq_valid | deq_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            rbin       <= '0;
            ridx_gray  <= '0;
            sink_valid <= 1'b0;
            deq_valid  <= 1'b0;
            deq_bits   <= '0;
        end else begin
            sink_valid <= 1'b1;
            if (!src_ok) begin
                // Source went away: drop anything pending and restart at 0.
                rbin      <= '0;
                ridx_gray <= '0;
                deq_valid <= 1'b0;
            end else if (load) begin
                // Load wins over a simultaneous pop so throughput stays 1/cycle.
                deq_bits  <= mem_entry[rbin[DEPTH_LOG2-1:0]];
                deq_valid <= 1'b1;
                rbin      <= next_rbin;
                ridx_gray <= next_rbin ^ (next_rbin >> 1);
            end else if (deq_valid && deq_ready) begin
                deq_valid <= 1'b0;
            end
        end
    end

`ifdef ASYNC_SINK_GRAY_CHECK_EN
    logic [PW-1:0] widx_prev;

    // A legal gray pointer moves at most one bit per sink cycle; anything more
    // means the crossing sampled a torn value. Ignored while the source is down
    // so that a source-side pointer reset is not reported.
    always_ff @(posedge clock) begin
        if (reset) begin
            widx_prev <= '0;
            gray_err  <= 1'b0;
        end else begin
            widx_prev <= widx_s;
            if (src_ok && ($countones(widx_s ^ widx_prev) > 1)) begin
                gray_err <= 1'b1;
            end
        end
    end
`else
    assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_queue_sink_rd.sv
// tb/tb_async_queue_sink_rd.sv - self-checking bench for async_queue_sink_rd

module tb_async_queue_sink_rd;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   widx_gray = '0;
    logic         source_valid = 1'b0;
    logic [255:0] mem_flat = '0;
    logic [3:0]   ridx_gray;
    logic         sink_valid;
    logic         deq_valid;
    logic         deq_ready = 1'b0;
    logic [31:0]  deq_bits;
    logic         gray_err;

    async_queue_sink_rd #(
        .DEPTH_LOG2 (3),
        .WIDTH      (32),
        .SYNC_STAGES(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .widx_gray   (widx_gray),
        .source_valid(source_valid),
        .mem_flat    (mem_flat),
        .ridx_gray   (ridx_gray),
        .sink_valid  (sink_valid),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_bits    (deq_bits),
        .gray_err    (gray_err)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] mem [8];
    logic [3:0]  wcnt;
    int          pushed;
    int          popped;
    logic [31:0] exp_q [$];
    logic        last_stall;
    logic [31:0] last_bits;
    logic [31:0] exp_front;
    logic        seen15;
    logic        seen_wrap;
    int          remaining;
    logic        exp_gerr;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Source side: write the next slot and advance the gray write index by one.
    task automatic push(input logic [31:0] d);
        mem[wcnt[2:0]] = d;
        for (int i = 0; i < 8; i++) mem_flat[i*32 +: 32] = mem[i];
        wcnt      = wcnt + 4'd1;
        widx_gray = gray4(wcnt);
        exp_q.push_back(d);
        pushed++;
    endtask

    // Scoreboard the transfer committed at the coming edge, then advance to
    // the following negative edge.
    task automatic tick();
        if (last_stall && deq_valid) chk("hold_stable", deq_bits, last_bits);
        if (deq_valid && deq_ready) begin
            chk("deq_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                exp_front = exp_q.pop_front();
                chk("deq_data", deq_bits, exp_front);
            end
            popped++;
        end
        last_stall = deq_valid & ~deq_ready;
        last_bits  = deq_bits;
        @(negedge clock);
    endtask

    task automatic do_reset();
        deq_ready = 1'b0;
        reset     = 1'b1;
        wcnt      = '0;
        widx_gray = '0;
        exp_q.delete();
        pushed = 0;
        popped = 0;
        tick();
        tick();
        chk("rst_sink_valid", {31'd0, sink_valid}, 32'd0);
        chk("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("rst_ridx", {28'd0, ridx_gray}, 32'd0);
        chk("rst_deq_bits", deq_bits, 32'd0);
        chk("rst_gray_err", {31'd0, gray_err}, 32'd0);
        reset = 1'b0;
        tick();
        chk("sink_valid_up", {31'd0, sink_valid}, 32'd1);
    endtask

    initial begin
        last_stall = 1'b0;
        last_bits  = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        @(negedge clock);

        // Reset release with an idle, alive source.
        source_valid = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("idle_deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("idle_ridx", {28'd0, ridx_gray}, 32'd0);

        // Single entry: latency is SYNC_STAGES+1 edges.
        deq_ready = 1'b1;
        push(32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lat_not_yet", {31'd0, deq_valid}, 32'd0);
        end
        tick();
        chk("lat_valid", {31'd0, deq_valid}, 32'd1);
        chk("lat_bits", deq_bits, 32'hDEADBEEF);
        chk("lat_ridx", {28'd0, ridx_gray}, 32'd1);
        tick();
        chk("lat_drop", {31'd0, deq_valid}, 32'd0);

        // Full queue held by backpressure, then drained back-to-back.
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 8; i++) begin
            push(i);
            tick();
        end
        chk("full_widx", {28'd0, widx_gray}, 32'hC);
        for (int i = 0; i < 6; i++) tick();
        chk("full_valid", {31'd0, deq_valid}, 32'd1);
        chk("full_bits", deq_bits, 32'd0);
        chk("full_ridx", {28'd0, ridx_gray}, {28'd0, gray4(4'd1)});
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_valid", {31'd0, deq_valid}, 32'd1);
            tick();
        end
        chk("drain_empty", {31'd0, deq_valid}, 32'd0);
        chk("drain_ridx", {28'd0, ridx_gray}, 32'hC);
        chk("drain_sb", exp_q.size(), 32'd0);

        // Wrap with random stalls: 20 entries from read index 8 to 28 (mod 16).
        seen15    = 1'b0;
        seen_wrap = 1'b0;
        remaining = 20;
        for (int c = 0; c < 600 && (remaining > 0 || exp_q.size() > 0); c++) begin
            if (remaining > 0 && (pushed - popped) < 8) begin
                push($urandom);
                remaining--;
            end
            deq_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (ridx_gray == 4'b1000) seen15 = 1'b1;
            if (seen15 && ridx_gray == 4'b0000) seen_wrap = 1'b1;
        end
        chk("wrap_all_pushed", remaining, 32'd0);
        chk("wrap_sb_empty", exp_q.size(), 32'd0);
        chk("wrap_seen15", {31'd0, seen15}, 32'd1);
        chk("wrap_seen0", {31'd0, seen_wrap}, 32'd1);
        tick();
        tick();
        chk("wrap_ridx", {28'd0, ridx_gray}, {28'd0, gray4(4'd12)});
        chk("wrap_gray_err", {31'd0, gray_err}, 32'd0);

        // Source reset with 3 entries pending.
        deq_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(32'hA000_0000 + i);
            tick();
        end
        for (int i = 0; i < 5; i++) tick();
        chk("flush_pre_valid", {31'd0, deq_valid}, 32'd1);
        source_valid = 1'b0;
        wcnt      = '0;
        widx_gray = '0;
        exp_q.delete();
        pushed = 0;
        popped = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("flush_valid", {31'd0, deq_valid}, 32'd0);
        chk("flush_ridx", {28'd0, ridx_gray}, 32'd0);
        deq_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("flush_no_deq", {31'd0, deq_valid}, 32'd0);
        end
        chk("flush_sink_valid", {31'd0, sink_valid}, 32'd1);
        source_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        push(32'h1234_5678);
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) tick();
        chk("resume_sb_empty", exp_q.size(), 32'd0);
        chk("resume_ridx", {28'd0, ridx_gray}, 32'd1);
        chk("resume_gray_err", {31'd0, gray_err}, 32'd0);

        // Multi-bit jump of the write index, then reset while a payload waits.
        do_reset();
        for (int i = 0; i < 5; i++) tick();
`ifdef ASYNC_SINK_GRAY_CHECK_EN
        exp_gerr = 1'b1;
`else
        exp_gerr = 1'b0;
`endif
        widx_gray = 4'b0011;
        for (int i = 0; i < 6; i++) tick();
        chk("gray_err_set", {31'd0, gray_err}, {31'd0, exp_gerr});
        widx_gray = 4'b0000;
        for (int i = 0; i < 6; i++) tick();
        chk("gray_err_sticky", {31'd0, gray_err}, {31'd0, exp_gerr});
        chk("midxfer_valid", {31'd0, deq_valid}, 32'd1);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
